// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing one instruction at a time,
// stalling in FETCH, MEMRD and MEMWR until memory signals mem_ready.
module mips_mc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    state_t cur_state, next_state;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur_state <= S_FETCH;
        else     cur_state <= next_state;
    end

    assign state = cur_state;

    // NOTE: every output and next_state gets a default first so no path infers a latch.
    always_comb begin
        next_state    = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        case (cur_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                next_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW)      next_state = S_MEMRD;
                else if (opcode == OP_SW) next_state = S_MEMWR;
            end
            S_MEMRD: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                next_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                next_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase

        // Outputs must drop the instant rst rises, before the state register is seen to change.
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
            illegal_op    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: the driver applies directed per-cycle vectors
// with hand-written expected states and pushes expectations; a negedge monitor compares.
module tb_mips_mc_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } out_t;

    typedef struct packed {
        logic [3:0] st;
        out_t       o;
        logic [7:0] tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    exp_t exp_q[$];

    mips_mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // Per-state output table written from the control specification.
    function automatic out_t spec_out(logic [3:0] st, logic [5:0] op, logic mr);
        out_t o = '0;
        case (st)
            4'd0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
            4'd1:  begin
                o.alu_src_b = 2'b11;
                if (!(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI})) o.illegal_op = 1;
            end
            4'd2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4'd3:  begin o.mem_read = 1; o.i_or_d = 1; end
            4'd4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            4'd5:  begin o.mem_write = 1; o.i_or_d = 1; end
            4'd6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            4'd7:  begin o.reg_write = 1; o.reg_dst = 1; end
            4'd8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
            4'd9:  begin o.pc_write = 1; o.pc_source = 2'b10; end
            4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4'd11: begin o.reg_write = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // One cycle of stimulus; st is the hand-derived state the DUT must be in during this cycle.
    task automatic step(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        opcode    = op;
        mem_ready = mr;
        e.st  = r ? 4'd0 : st;
        e.o   = r ? out_t'('0) : spec_out(st, op, mr);
        e.tag = 8'(step_no);
        step_no++;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        out_t act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = '{pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                        mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                        pc_source, illegal_op};
                check($sformatf("state@step%0d", e.tag), 32'(state), 32'(e.st));
                check($sformatf("outputs@step%0d", e.tag), 32'(act), 32'(e.o));
                check($sformatf("pcw_excl@step%0d", e.tag), 32'(pc_write & pc_write_cond), 32'd0);
            end
        end
    end

    initial begin
        // Reset held
        step(1, OP_LW, 1, 0);
        step(1, OP_LW, 1, 0);
        // LW, no waits: 0,1,2,3,4
        step(0, OP_LW, 1, 0);
        step(0, OP_LW, 1, 1);
        step(0, OP_LW, 1, 2);
        step(0, OP_LW, 1, 3);
        step(0, OP_LW, 1, 4);
        // SW with 3 wait cycles in MEMWR
        step(0, OP_SW, 1, 0);
        step(0, OP_SW, 0, 1);
        step(0, OP_SW, 0, 2);
        step(0, OP_SW, 0, 5);
        step(0, OP_SW, 0, 5);
        step(0, OP_SW, 0, 5);
        step(0, OP_SW, 1, 5);
        // BEQ: 0,1,8
        step(0, OP_BEQ, 1, 0);
        step(0, OP_BEQ, 1, 1);
        step(0, OP_BEQ, 1, 8);
        // R-type with 2 wait cycles in FETCH; mem_ready low in EXEC is ignored
        step(0, OP_RTYPE, 0, 0);
        step(0, OP_RTYPE, 0, 0);
        step(0, OP_RTYPE, 1, 0);
        step(0, OP_RTYPE, 1, 1);
        step(0, OP_RTYPE, 0, 6);
        step(0, OP_RTYPE, 0, 7);
        // ADDI: 0,1,10,11
        step(0, OP_ADDI, 1, 0);
        step(0, OP_ADDI, 1, 1);
        step(0, OP_ADDI, 1, 10);
        step(0, OP_ADDI, 1, 11);
        // J: 0,1,9
        step(0, OP_J, 1, 0);
        step(0, OP_J, 1, 1);
        step(0, OP_J, 1, 9);
        // Illegal opcode: pulse in DECODE, back to FETCH
        step(0, OP_BAD, 1, 0);
        step(0, OP_BAD, 1, 1);
        // LW stalled in MEMRD, then reset raised mid-cycle
        step(0, OP_LW, 1, 0);
        step(0, OP_LW, 1, 1);
        step(0, OP_LW, 0, 2);
        step(0, OP_LW, 0, 3);
        step(0, OP_LW, 0, 3);
        step(1, OP_LW, 0, 0);
        step(1, OP_LW, 1, 0);
        // Fresh fetch after release
        step(0, OP_J, 1, 0);
        step(0, OP_J, 1, 1);
        step(0, OP_J, 1, 9);
        step(0, OP_J, 0, 0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
